// File: rtl/bitser_pkg.sv
// Shared types and constants for the bit-serial ALU operand sequencer.
package bitser_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned OP_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [OP_W-1:0] OP_NEG = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_AND = 4'b1010;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1100;

endpackage

// File: rtl/bitser_operand_seq_if.sv
// Host-side load/start bus of the operand sequencer.
interface bitser_operand_seq_if;
  import bitser_pkg::*;

  logic              load_valid;
  logic [NIB_W-1:0]  load_data;
  logic              load_ready;
  logic [OP_W-1:0]   op_in;
  logic              start;

  modport master (
    output load_valid, load_data, op_in, start,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_data, op_in, start,
    output load_ready
  );
endinterface

// File: rtl/bitser_result_sipo.sv
// Shift-in result register: new bits enter at the MSB, so the first bit ends at the LSB.
module bitser_result_sipo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/bitser_operand_seq.sv
// Operand loader, LSB-first streamer and result collector for the bit-serial ALU.
module bitser_operand_seq
  import bitser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bitser_operand_seq_if.slave  lif,
  input  logic                 res_bit,
  output logic [OP_W-1:0]      alu_op,
  output logic                 alu_a,
  output logic                 alu_b,
  output logic                 alu_rstn,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid
);

  localparam int unsigned NA     = WIDTH / NIB_W;
  localparam int unsigned NSLOT  = 2 * NA;
  localparam int unsigned NIB_CW = $clog2(NSLOT);
  localparam int unsigned BIT_CW = $clog2(WIDTH);

  state_e              state;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [NIB_CW-1:0]   nib_cnt;
  logic [BIT_CW-1:0]   bit_cnt;

  logic idle_or_done_c;
  logic start_acc_c;
  logic shift_c;

  assign idle_or_done_c = (state == IDLE) || (state == DONE);
  assign start_acc_c    = idle_or_done_c && lif.start;
  assign lif.load_ready = idle_or_done_c && !lif.start;

  // res_bit lags alu_a/alu_b by one cycle, so the first RUN cycle has nothing to capture
  assign shift_c = ((state == RUN) && (bit_cnt != '0)) || (state == DRAIN);

  bitser_result_sipo #(.WIDTH(WIDTH)) u_sipo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc_c),
    .shift (shift_c),
    .din   (res_bit),
    .q     (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      nib_cnt      <= '0;
      bit_cnt      <= '0;
      alu_op       <= '0;
      alu_a        <= 1'b0;
      alu_b        <= 1'b0;
      alu_rstn     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (lif.start) begin
            state        <= RUN;
            alu_op       <= lif.op_in;
            bit_cnt      <= '0;
            alu_a        <= op_a[0];
            alu_b        <= op_b[0];
            alu_rstn     <= 1'b1;
            busy         <= 1'b1;
            result_valid <= 1'b0;
          end else if (lif.load_valid) begin
            for (int unsigned s = 0; s < NA; s++) begin
              if (nib_cnt == NIB_CW'(s))
                op_a[s*NIB_W +: NIB_W] <= lif.load_data;
              if (nib_cnt == NIB_CW'(NA + s))
                op_b[s*NIB_W +: NIB_W] <= lif.load_data;
            end
            nib_cnt      <= (nib_cnt == NIB_CW'(NSLOT - 1)) ? '0 : nib_cnt + NIB_CW'(1);
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        RUN: begin
          // WIDTH rotations restore the operands, so a rerun needs no reload
          op_a    <= {op_a[0], op_a[WIDTH-1:1]};
          op_b    <= {op_b[0], op_b[WIDTH-1:1]};
          bit_cnt <= bit_cnt + BIT_CW'(1);
          if (bit_cnt == BIT_CW'(WIDTH - 1)) begin
            state    <= DRAIN;
            alu_a    <= 1'b0;
            alu_b    <= 1'b0;
            alu_rstn <= 1'b0;
          end else begin
            alu_a <= op_a[1];
            alu_b <= op_b[1];
          end
        end
        DRAIN: begin
          state        <= DONE;
          busy         <= 1'b0;
          done         <= 1'b1;
          result_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitser_operand_seq.sv
// Self-checking bench for bitser_operand_seq with a behavioural bit-serial ALU.
module tb_bitser_operand_seq;
  import bitser_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitser_operand_seq_if lif();

  logic             res_bit;
  logic [OP_W-1:0]  alu_op;
  logic             alu_a, alu_b, alu_rstn, busy, done;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  bitser_operand_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .lif          (lif),
    .res_bit      (res_bit),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_rstn     (alu_rstn),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid)
  );

  // Behavioural serial ALU: registered output, carry/borrow held clear while alu_rstn is low
  logic alu_c;
  always_ff @(posedge clk) begin
    if (!alu_rstn) begin
      alu_c   <= 1'b0;
      res_bit <= 1'b0;
    end else begin
      case (alu_op)
        OP_ADD: begin
          res_bit <= alu_a ^ alu_b ^ alu_c;
          alu_c   <= (alu_a & alu_b) | (alu_c & (alu_a ^ alu_b));
        end
        OP_OR:   res_bit <= alu_a | alu_b;
        OP_AND:  res_bit <= alu_a & alu_b;
        OP_XOR:  res_bit <= alu_a ^ alu_b;
        OP_NOT:  res_bit <= ~alu_a;
        default: begin
          res_bit <= alu_a ^ alu_c;
          alu_c   <= alu_a | alu_c;
        end
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_nib(input logic [3:0] n);
    @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = n;
    @(negedge clk);
    lif.load_valid = 1'b0;
  endtask

  // Start a run, push its expectation, watch 14 cycles; optionally re-assert start mid-run
  task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] exp, input int ign_cyc,
                        input logic with_nib, output int lat, output int rstn_hi, output int n_done);
    logic [WIDTH-1:0] e;
    lat = 0; rstn_hi = 0; n_done = 0;
    @(negedge clk);
    lif.start      = 1'b1;
    lif.op_in      = op;
    lif.load_valid = with_nib;
    lif.load_data  = 4'h7;
    exp_q.push_back(exp);
    #1;
    if (with_nib) check_eq("start_blocks_load_ready", 32'(lif.load_ready), 32'(0));
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      lif.start      = 1'b0;
      lif.load_valid = 1'b0;
      if (alu_rstn) rstn_hi++;
      if (done) begin
        n_done++;
        lat = cyc;
        check_eq("sb_pending", 32'(exp_q.size()), 32'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("result", 32'(result), 32'(e));
          check_eq("result_valid", 32'(result_valid), 32'(1));
        end
      end
      if (cyc == ign_cyc) begin
        check_eq("busy_mid_run", 32'(busy), 32'(1));
        check_eq("load_ready_busy", 32'(lif.load_ready), 32'(0));
        lif.start = 1'b1;
        lif.op_in = OP_AND;
      end
    end
    if (n_done == 0) exp_q.delete();
  endtask

  int lat, rh, nd;

  initial begin
    rst            = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.op_in      = '0;
    lif.start      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",         32'(busy), 32'(0));
    check_eq("rst_done",         32'(done), 32'(0));
    check_eq("rst_alu_rstn",     32'(alu_rstn), 32'(0));
    check_eq("rst_alu_ab",       32'({alu_a, alu_b}), 32'(0));
    check_eq("rst_alu_op",       32'(alu_op), 32'(0));
    check_eq("rst_result",       32'(result), 32'(0));
    check_eq("rst_result_valid", 32'(result_valid), 32'(0));
    check_eq("rst_load_ready",   32'(lif.load_ready), 32'(1));
    rst = 1'b0;

    // A=0x5A, B=0x33, ADD
    load_nib(4'hA); load_nib(4'h5); load_nib(4'h3); load_nib(4'h3);
    run_op(OP_ADD, 8'h8D, 0, 1'b0, lat, rh, nd);
    check_eq("add_latency", 32'(lat), 32'(10));
    check_eq("add_rstn_cycles", 32'(rh), 32'(8));
    check_eq("add_done_once", 32'(nd), 32'(1));
    check_eq("idle_alu_ab", 32'({alu_a, alu_b}), 32'(0));

    // A=0xF0, B=0x3C: XOR, then AND straight from DONE without reload
    load_nib(4'h0); load_nib(4'hF); load_nib(4'hC); load_nib(4'h3);
    run_op(OP_XOR, 8'hCC, 0, 1'b0, lat, rh, nd);
    check_eq("xor_done_once", 32'(nd), 32'(1));
    run_op(OP_AND, 8'h30, 0, 1'b0, lat, rh, nd);
    check_eq("and_rerun_latency", 32'(lat), 32'(10));

    // Reset in RUN cycle 3 of a NOT run
    @(negedge clk);
    lif.start = 1'b1;
    lif.op_in = OP_NOT;
    repeat (4) begin
      @(negedge clk);
      lif.start = 1'b0;
    end
    check_eq("pre_rst_busy", 32'(busy), 32'(1));
    check_eq("pre_rst_partial_result", 32'(result), 32'(8'hC0));
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'(0));
    check_eq("mid_rst_alu_rstn", 32'(alu_rstn), 32'(0));
    check_eq("mid_rst_result", 32'(result), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_load_ready", 32'(lif.load_ready), 32'(1));
    check_eq("post_rst_busy", 32'(busy), 32'(0));

    // Start beats a simultaneous nibble: A=0xA5, B stays 0, nib_cnt stays at 2
    load_nib(4'h5); load_nib(4'hA);
    run_op(OP_OR, 8'hA5, 0, 1'b1, lat, rh, nd);
    check_eq("or_done_once", 32'(nd), 32'(1));
    load_nib(4'h1);
    check_eq("done_exit_result_valid", 32'(result_valid), 32'(0));
    check_eq("done_exit_result_hold", 32'(result), 32'(8'hA5));
    load_nib(4'h3);
    run_op(OP_ADD, 8'hD6, 0, 1'b0, lat, rh, nd);
    check_eq("slot_b_add_done", 32'(nd), 32'(1));

    // Five nibbles: wrap overwrites A[3:0] -> A=0x29, B=0x43
    load_nib(4'h1); load_nib(4'h2); load_nib(4'h3); load_nib(4'h4); load_nib(4'h9);
    run_op(OP_ADD, 8'h6C, 0, 1'b0, lat, rh, nd);
    check_eq("wrap_add_done", 32'(nd), 32'(1));

    // Start during RUN is ignored
    run_op(OP_XOR, 8'h6A, 4, 1'b0, lat, rh, nd);
    check_eq("ign_start_done_once", 32'(nd), 32'(1));
    check_eq("ign_start_latency", 32'(lat), 32'(10));
    check_eq("ign_start_alu_op", 32'(alu_op), 32'(OP_XOR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
